// File: rtl/uart_cmd_tx_if.sv
// Handshake bundle for the UART command transmitter: frame request in, status and serial line out.
// The slave modport is the transmitter; the master modport is whoever issues frames.
interface uart_cmd_tx_if;
   logic        start;
   logic [7:0]  cmd;
   logic [31:0] value;
   logic        ready;
   logic        busy;
   logic        done;
   logic        TX;

   modport master (
      output start, cmd, value,
      input  ready, busy, done, TX
   );

   modport slave (
      input  start, cmd, value,
      output ready, busy, done, TX
   );
endinterface

// File: rtl/uart_cmd_tx.sv
// Serialises one command frame (cmd byte, then 32-bit value MSB first) as five 8N1 UART bytes,
// with optional idle-high gap bits after each stop bit and back-to-back frame acceptance.
module uart_cmd_tx #(
   parameter int CLKS_PER_BIT = 104,
   parameter int GAP_BITS     = 0
) (
   input  logic         clk,
   input  logic         rst,
   uart_cmd_tx_if.slave bus
);

   localparam int               TICK_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       GAP_LAST  = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;
   localparam logic [2:0]       LAST_BYTE = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_GAP
   } state_t;

   state_t              state_q, state_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic [2:0]          bit_q, bit_d;
   logic [2:0]          byte_q, byte_d;
   logic [3:0]          gap_q, gap_d;
   logic [39:0]         frame_q, frame_d;
   logic                tx_q, tx_d;

   logic                tick_end;
   logic                byte_end;
   logic                frame_end;
   logic                ready;
   logic [7:0]          cur_byte;

   assign tick_end = (tick_q == TICK_LAST);
   // The byte on the wire always sits in the top 8 bits; later bytes shift up as each one finishes.
   assign cur_byte = frame_q[39:32];

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      byte_d    = byte_q;
      gap_d     = gap_q;
      frame_d   = frame_q;
      tx_d      = tx_q;
      byte_end  = 1'b0;
      frame_end = 1'b0;

      if (state_q != ST_IDLE) begin
         tick_d = tick_end ? '0 : tick_q + 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
         end
         ST_START: begin
            if (tick_end) begin
               state_d = ST_DATA;
               bit_d   = '0;
               tx_d    = cur_byte[0];
            end
         end
         ST_DATA: begin
            if (tick_end) begin
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = cur_byte[bit_q + 3'd1];
               end
            end
         end
         ST_STOP: begin
            if (tick_end) begin
               if (GAP_BITS > 0) begin
                  state_d = ST_GAP;
                  gap_d   = '0;
               end else begin
                  byte_end = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (tick_end) begin
               if (gap_q == GAP_LAST) begin
                  byte_end = 1'b1;
               end else begin
                  gap_d = gap_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      if (byte_end) begin
         if (byte_q == LAST_BYTE) begin
            frame_end = 1'b1;
            state_d   = ST_IDLE;
            tx_d      = 1'b1;
         end else begin
            state_d = ST_START;
            byte_d  = byte_q + 3'd1;
            frame_d = {frame_q[31:0], 8'h00};
            tx_d    = 1'b0;
         end
      end

      // Ready during the final tick lets a new frame start with no idle cycle in between.
      ready = (state_q == ST_IDLE) || frame_end;

      if (ready && bus.start) begin
         state_d = ST_START;
         tick_d  = '0;
         bit_d   = '0;
         byte_d  = '0;
         gap_d   = '0;
         frame_d = {bus.cmd, bus.value};
         tx_d    = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         gap_q   <= '0;
         frame_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         gap_q   <= gap_d;
         frame_q <= frame_d;
         tx_q    <= tx_d;
      end
   end

   // Gating with rst keeps an aborted frame from ever reporting completion.
   assign bus.done  = frame_end && !rst;
   assign bus.ready = ready;
   assign bus.busy  = !ready;
   assign bus.TX    = tx_q;

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Bench for uart_cmd_tx: two instances (4 clk/bit no gap, 7 clk/bit 2 gap bits), UART decoders and
// scoreboard queues for decoded bytes and done-pulse cycles.
module tb_uart_cmd_tx;

   localparam int CPB_A = 4;
   localparam int GAP_A = 0;
   localparam int CPB_B = 7;
   localparam int GAP_B = 2;
   localparam int LEN_A = 5 * (10 + GAP_A) * CPB_A;
   localparam int LEN_B = 5 * (10 + GAP_B) * CPB_B;

   typedef struct {
      logic [7:0]      cmd;
      logic [31:0]     value;
      logic [0:4][7:0] bytes;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   gen = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];
   int         done_a[$];
   int         done_b[$];
   vec_t       vecs[8];

   uart_cmd_tx_if bus_a ();
   uart_cmd_tx_if bus_b ();

   uart_cmd_tx #(.CLKS_PER_BIT(CPB_A), .GAP_BITS(GAP_A)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.slave)
   );

   uart_cmd_tx #(.CLKS_PER_BIT(CPB_B), .GAP_BITS(GAP_B)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic tx_of(input int sel);
      return (sel == 0) ? bus_a.TX : bus_b.TX;
   endfunction

   function automatic logic [3:0] status_of(input int sel);
      if (sel == 0) return {bus_a.TX, bus_a.ready, bus_a.busy, bus_a.done};
      return {bus_b.TX, bus_b.ready, bus_b.busy, bus_b.done};
   endfunction

   task automatic set_in(input int sel, input logic s, input logic [7:0] c, input logic [31:0] v);
      if (sel == 0) begin
         bus_a.start = s; bus_a.cmd = c; bus_a.value = v;
      end else begin
         bus_b.start = s; bus_b.cmd = c; bus_b.value = v;
      end
   endtask

   task automatic push_frame(input int sel, input vec_t v, input int done_cyc);
      for (int i = 0; i < 5; i++) begin
         if (sel == 0) exp_a.push_back(v.bytes[i]);
         else          exp_b.push_back(v.bytes[i]);
      end
      if (sel == 0) done_a.push_back(done_cyc);
      else          done_b.push_back(done_cyc);
   endtask

   // Decodes one byte per falling edge, sampling each bit at its middle. Bytes cut by a reset are dropped.
   task automatic rx_loop(input int sel, input int cpb);
      logic [7:0] b;
      logic [7:0] e;
      logic       s0;
      logic       sp;
      int         g;
      forever begin
         @(negedge clk);
         if (!rst && tx_of(sel) === 1'b0) begin
            g = gen;
            repeat (cpb / 2) @(negedge clk);
            s0 = tx_of(sel);
            for (int i = 0; i < 8; i++) begin
               repeat (cpb) @(negedge clk);
               b[i] = tx_of(sel);
            end
            repeat (cpb) @(negedge clk);
            sp = tx_of(sel);
            if (g == gen) begin
               if (sel == 0) e = (exp_a.size() > 0) ? exp_a.pop_front() : 8'hxx;
               else          e = (exp_b.size() > 0) ? exp_b.pop_front() : 8'hxx;
               check((sel == 0) ? "rx_a_start_bit" : "rx_b_start_bit", s0, 1'b0);
               check((sel == 0) ? "rx_a_byte" : "rx_b_byte", b, e);
               check((sel == 0) ? "rx_a_stop_bit" : "rx_b_stop_bit", sp, 1'b1);
            end
         end
      end
   endtask

   // done sampled at the negedge where cyc equals acceptance edge + frame length - 1.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus_a.done !== 1'b0) begin
            if (done_a.size() == 0) check("done_a_unexpected", bus_a.done, 1'b0);
            else                    check("done_a_cycle", cyc, done_a.pop_front());
         end
         if (bus_b.done !== 1'b0) begin
            if (done_b.size() == 0) check("done_b_unexpected", bus_b.done, 1'b0);
            else                    check("done_b_cycle", cyc, done_b.pop_front());
         end
      end
   end

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      gen++;
      exp_a.delete(); exp_b.delete(); done_a.delete(); done_b.delete();
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   // Drives one start pulse on an idle DUT; acc is the cycle count of the accepting edge.
   task automatic send(input int sel, input vec_t v, output int acc);
      int c;
      @(negedge clk);
      check("pre_accept_ready", status_of(sel) & 4'b0100, 4'b0100);
      c = cyc;
      set_in(sel, 1'b1, v.cmd, v.value);
      push_frame(sel, v, c + ((sel == 0) ? LEN_A : LEN_B));
      @(negedge clk);
      set_in(sel, 1'b0, 8'h00, 32'h0);
      acc = c + 1;
      check("accept_latency_status", status_of(sel), 4'b0010);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((done_a.size() + done_b.size() + exp_a.size() + exp_b.size()) != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle_timeout", done_a.size() + done_b.size() + exp_a.size() + exp_b.size(), 0);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int acc;
      int c;

      vecs[0] = '{8'h02, 32'h12345678, {8'h02, 8'h12, 8'h34, 8'h56, 8'h78}};
      vecs[1] = '{8'h05, 32'hAAAA5555, {8'h05, 8'hAA, 8'hAA, 8'h55, 8'h55}};
      vecs[2] = '{8'h01, 32'h00000003, {8'h01, 8'h00, 8'h00, 8'h00, 8'h03}};
      vecs[3] = '{8'h0F, 32'h00000000, {8'h0F, 8'h00, 8'h00, 8'h00, 8'h00}};
      vecs[4] = '{8'h03, 32'hCAFEBABE, {8'h03, 8'hCA, 8'hFE, 8'hBA, 8'hBE}};
      vecs[5] = '{8'h0C, 32'h0000001F, {8'h0C, 8'h00, 8'h00, 8'h00, 8'h1F}};
      vecs[6] = '{8'h0B, 32'h000000C8, {8'h0B, 8'h00, 8'h00, 8'h00, 8'hC8}};
      vecs[7] = '{8'hA5, 32'h8001FF7E, {8'hA5, 8'h80, 8'h01, 8'hFF, 8'h7E}};

      set_in(0, 1'b0, 8'h00, 32'h0);
      set_in(1, 1'b0, 8'h00, 32'h0);

      fork
         rx_loop(0, CPB_A);
         rx_loop(1, CPB_B);
      join_none

      // Reset for 3 cycles, then idle outputs must hold for 100 cycles.
      do_reset(3);
      for (int i = 0; i < 100; i++) begin
         check("idle_after_reset_a", status_of(0), 4'b1100);
         if (i % 25 == 0) check("idle_after_reset_b", status_of(1), 4'b1100);
         @(negedge clk);
      end

      // Single frames from the table on the 4-clk/bit instance.
      foreach (vecs[k]) begin
         if (k == 0 || k == 7) begin
            send(0, vecs[k], acc);
            wait_idle(LEN_A + 50);
         end
      end

      // start while busy is ignored.
      send(0, vecs[1], acc);
      while (cyc < acc + 50) @(negedge clk);
      set_in(0, 1'b1, 8'hFF, 32'hFFFFFFFF);
      check("busy_mid_frame", status_of(0) & 4'b0110, 4'b0010);
      @(negedge clk);
      set_in(0, 1'b0, 8'h00, 32'h0);
      wait_idle(LEN_A + 50);

      // Back-to-back frames with start held high.
      @(negedge clk);
      c = cyc;
      set_in(0, 1'b1, vecs[2].cmd, vecs[2].value);
      push_frame(0, vecs[2], c + LEN_A);
      @(negedge clk);
      set_in(0, 1'b1, vecs[3].cmd, vecs[3].value);
      push_frame(0, vecs[3], c + 2 * LEN_A);
      while (cyc < c + LEN_A) @(negedge clk);
      check("b2b_done_cycle_status", status_of(0), 4'b1101);
      @(negedge clk);
      set_in(0, 1'b0, 8'h00, 32'h0);
      check("b2b_second_start_bit", status_of(0), 4'b0010);
      wait_idle(2 * LEN_A + 50);

      // Reset during data bit 3 of byte 2, then a clean frame.
      send(0, vecs[4], acc);
      while (cyc < acc + 97) @(negedge clk);
      rst = 1'b1;
      gen++;
      exp_a.delete(); done_a.delete();
      @(negedge clk);
      rst = 1'b0;
      check("reset_mid_frame_status", status_of(0), 4'b1100);
      repeat (60) @(negedge clk);
      check("reset_mid_frame_quiet", status_of(0), 4'b1100);
      send(0, vecs[5], acc);
      wait_idle(LEN_A + 50);

      // Gap bits on the 7-clk/bit instance: stop + 14 gap cycles high, then next start bit.
      send(1, vecs[6], acc);
      while (cyc < acc + 63) @(negedge clk);
      for (int i = 0; i < 21; i++) begin
         check("gap_stop_high", tx_of(1), 1'b1);
         @(negedge clk);
      end
      check("gap_next_start_bit", tx_of(1), 1'b0);
      wait_idle(LEN_B + 50);

      check("leftover_bytes", exp_a.size() + exp_b.size(), 0);
      check("leftover_dones", done_a.size() + done_b.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      n_errors++;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
